alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the datapath's combinational 32-bit ALU.
- Keeps the eight base opcodes at the same encodings and adds shifts, an iterative multiply, status flags and an illegal-op indication.
- Has a registered output with valid/ready on both sides, so it can sit between an issue stage and writeback with back-pressure.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two, >= 4.
- SHW, $clog2(WIDTH), derived shift-amount width; not to be overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request this cycle.
- ALU_control  input  4  opcode.
- in_A  input  WIDTH  operand A.
- in_B  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result.
- flags  output  4  {negative, zero, carry, overflow}.
- illegal_op  output  1  result came from an undefined opcode.

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous, active-low.
  - Reset clears: out=0, flags=0, illegal_op=0, out_valid=0, state=IDLE, iteration counter=0.
  - Reset mid-multiply abandons the operation; no result is produced.
- Opcodes:
  - 0 ~A; 1 A&B; 2 A^B; 3 A|B; 4 A-1; 5 A+B; 6 A-B; 7 A+1.
  - 8 A<<B[SHW-1:0]; 9 A>>B[SHW-1:0] logical; 10 A>>>B[SHW-1:0] arithmetic.
  - 11 MUL: low WIDTH bits of the unsigned product A*B.
  - 12-15 undefined: out=0, illegal_op=1.
- Accept: on a rising edge where in_valid && in_ready, capture ALU_control, in_A and in_B. Inputs are ignored at all other times.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- States:
  - IDLE: accept a non-MUL op -> result and flags registered at the same edge; out_valid=1 from the next cycle; stay in IDLE. Back-to-back throughput is 1/cycle while out_ready=1.
  - IDLE: accept MUL -> go to MUL. Accumulator=0, counter=0.
  - MUL: one shift-add step per cycle (add multiplicand if the multiplier LSB is 1; shift multiplicand left, multiplier right); in_ready=0.
  - MUL -> IDLE after WIDTH steps: out, flags and out_valid are loaded at the edge of the last step. Latency is WIDTH cycles from the accept edge to out_valid.
- Output hold:
  - out_valid && !out_ready: out, flags and illegal_op hold stable and no new op is accepted.
  - out_valid drops on an edge with out_ready=1 unless a new non-MUL op is accepted on that same edge.
- Flags, all computed at WIDTH bits:
  - negative = out[WIDTH-1]; zero = (out==0).
  - carry: carry-out for ops 5 and 7; borrow (1 when the unsigned subtrahend > minuend) for ops 4 and 6; 0 for all other ops.
  - overflow: signed overflow for ops 4-7; 0 otherwise.
  - Wrap-around: all-ones+1 -> out=0, zero=1, carry=1. 0-1 -> all-ones, carry=1.
- Shifts:
  - Shift amount is taken modulo WIDTH; shift by 0 passes A through.
  - Arithmetic shift replicates A[WIDTH-1].
- Undefined opcodes: illegal_op=1 and zero=1, other flags 0. These take the single-cycle path.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- When defined: opcode 11 is the iterative multiply as above.
- When undefined:
  - The MUL state, counter and accumulator are not built.
  - Opcode 11 is treated as undefined: single-cycle, out=0, illegal_op=1.

Test Plan:
- WIDTH=32, reset mid-stream: assert rst_n=0 asynchronously while out_valid=1 -> out_valid, out, flags and illegal_op go to 0 immediately, without waiting for a clock edge.
- Op 5, A=32'hFFFFFFFF, B=1, out_ready=1 -> one cycle later out_valid=1, out=0, flags=4'b0110.
- Op 6, A=0x7FFFFFFF, B=0xFFFFFFFF -> out=0x80000000, flags negative=1, carry=1, overflow=1. Op 10, A=0x80000000, B=35 -> out=0xF0000000.
- Op 11, A=1234, B=5678, with MUL_EN -> in_ready=0 for 32 cycles, then out=7006652. Without MUL_EN -> out=0 after 1 cycle, illegal_op=1.
- Back-pressure: hold out_ready=0 with ops 1 then 3 queued -> first result (0x0F&0xFF=0x0F) holds stable and in_ready=0. Releasing out_ready -> second result appears the next cycle.
- Streaming: 8 consecutive ops 0-7 with in_valid=1 and out_ready=1 -> 8 results on 8 consecutive cycles, matching a reference model.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU.
//
// Opcodes 0-7 keep the encodings of the original combinational ALU.
// Opcodes 8-10 are shifts, and opcode 11 is an iterative unsigned multiply
// that returns the low WIDTH bits. Opcodes 12-15 return out=0 with
// illegal_op=1.
//
// Optional feature macro: ALU_PIPE_MUL_EN
//   defined   : opcode 11 runs a WIDTH-step shift-add multiply (MUL state).
//   undefined : no multiply hardware is built; opcode 11 behaves as an
//               undefined opcode and takes one cycle.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side. in_ready is a pure function of registered state
// and out_ready. While out_valid && !out_ready, out/flags/illegal_op hold.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  request handshake
//   ALU_control          4-bit opcode
//   in_A, in_B           operands (WIDTH bits)
//   out_valid/out_ready  result handshake
//   out                  registered result (WIDTH bits)
//   flags                {negative, zero, carry, overflow}
//   illegal_op           result came from an undefined opcode
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALU_control,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             illegal_op
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             accept;
  logic             is_mul;
  logic             out_free;

  // Single-cycle datapath results.
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;

  // Shared add/subtract unit for ops 4-7.
  logic [WIDTH-1:0] arith_b;
  logic             arith_sub;
  logic [WIDTH:0]   arith_ext;
  logic [WIDTH-1:0] arith_res;
  logic             arith_v;
  logic [SHW-1:0]   sh;

  assign out_free = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign sh       = in_B[SHW-1:0];

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;
  logic             mul_last;

  assign is_mul   = (ALU_control == 4'd11);
  assign in_ready = (state == IDLE) && out_free;
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && is_mul) state_next = MUL;
      MUL:  if (mul_last)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiplier datapath: cnt counts completed steps, so the step taken
  // while cnt == WIDTH-1 is the last one and also loads the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (state == IDLE) begin
      if (accept && is_mul) begin
        cnt    <= '0;
        acc    <= '0;
        mcand  <= in_A;
        mplier <= in_B;
      end
    end else begin
      cnt    <= cnt + SHW'(1);
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign in_ready = out_free;
`endif

  // Ops 4 and 7 reuse the adder with a constant 1 operand.
  always_comb begin
    arith_b   = in_B;
    arith_sub = 1'b0;
    case (ALU_control)
      4'd4:    begin arith_b = ONE;  arith_sub = 1'b1; end
      4'd6:    begin arith_b = in_B; arith_sub = 1'b1; end
      4'd7:    begin arith_b = ONE;  arith_sub = 1'b0; end
      default: begin arith_b = in_B; arith_sub = 1'b0; end
    endcase
  end

  // The extra top bit is carry-out for add and borrow for subtract.
  assign arith_ext = arith_sub ? ({1'b0, in_A} - {1'b0, arith_b})
                               : ({1'b0, in_A} + {1'b0, arith_b});
  assign arith_res = arith_ext[WIDTH-1:0];
  assign arith_v   = arith_sub
      ? ((in_A[WIDTH-1] != arith_b[WIDTH-1]) && (arith_res[WIDTH-1] != in_A[WIDTH-1]))
      : ((in_A[WIDTH-1] == arith_b[WIDTH-1]) && (arith_res[WIDTH-1] != in_A[WIDTH-1]));

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (ALU_control)
      4'd0:  alu_res = ~in_A;
      4'd1:  alu_res = in_A & in_B;
      4'd2:  alu_res = in_A ^ in_B;
      4'd3:  alu_res = in_A | in_B;
      4'd4, 4'd5, 4'd6, 4'd7: begin
        alu_res = arith_res;
        alu_c   = arith_ext[WIDTH];
        alu_v   = arith_v;
      end
      4'd8:  alu_res = in_A << sh;
      4'd9:  alu_res = in_A >> sh;
      4'd10: alu_res = $unsigned($signed(in_A) >>> sh);
`ifdef ALU_PIPE_MUL_EN
      // Result comes from the MUL state, not from this path.
      4'd11: alu_res = '0;
`endif
      default: begin
        alu_res = '0;
        alu_ill = 1'b1;
      end
    endcase
  end

  // Output register. A consumed result drops out_valid unless a new
  // single-cycle result is loaded on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out        <= '0;
      flags      <= 4'b0000;
      illegal_op <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && !is_mul) begin
        out        <= alu_res;
        flags      <= {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
        illegal_op <= alu_ill;
        out_valid  <= 1'b1;
      end
`ifdef ALU_PIPE_MUL_EN
      if (state == MUL && mul_last) begin
        out        <= acc_next;
        flags      <= {acc_next[WIDTH-1], (acc_next == '0), 2'b00};
        illegal_op <= 1'b0;
        out_valid  <= 1'b1;
      end
`endif
    end
  end

endmodule
